// File: rtl/queue_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : queue_arbiter_rr
// Brief    : Registered arbiter selecting one request per cycle from Q_WIDTH
//            cache request queues onto a single valid/ready output channel.
//            Flush requests take precedence; round-robin or fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module queue_arbiter_rr #(
  parameter int CL_SIZE = 128,
  parameter int Q_WIDTH = 6,
  parameter int ADDR_W  = 32,
  parameter int OP_W    = 3,
  parameter int ID_W    = 2,
  parameter int RR_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W*Q_WIDTH-1:0]  addr_in,
  input  logic [CL_SIZE*Q_WIDTH-1:0] data_in,
  input  logic [OP_W*Q_WIDTH-1:0]    operation_in,
  input  logic [ID_W*Q_WIDTH-1:0]    src_in,
  input  logic [ID_W*Q_WIDTH-1:0]    dest_in,
  input  logic [Q_WIDTH-1:0]         is_flush_in,
  input  logic [Q_WIDTH-1:0]         valid_in,
  output logic [Q_WIDTH-1:0]         dealloc,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [ADDR_W-1:0]          addr_out,
  output logic [CL_SIZE-1:0]         data_out,
  output logic [OP_W-1:0]            operation_out,
  output logic [ID_W-1:0]            src_out,
  output logic [ID_W-1:0]            dest_out,
  output logic                       is_flush_out
);

  localparam int PTR_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic               valid_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CL_SIZE-1:0] data_q;
  logic [OP_W-1:0]    op_q;
  logic [ID_W-1:0]    src_q;
  logic [ID_W-1:0]    dest_q;
  logic               flush_q;

  logic [Q_WIDTH-1:0] flush_req;
  logic [Q_WIDTH-1:0] cand;
  logic               load;
  logic [PTR_W-1:0]   grant_idx;
  logic               found;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W:0]     ptr_inc;

  // Flush requests, when present, hide every non-flush request.
  assign flush_req = valid_in & is_flush_in;
  assign cand      = (|flush_req) ? flush_req : valid_in;

  // Load when something is requesting and the output slot is free or draining.
  // Gating with rst_n keeps dealloc quiet while reset is held.
  assign load = rst_n && (|valid_in) && (!valid_q || ready_in);

  // Grant selection: scan upward from ptr (round-robin) or take the top index.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (RR_MODE != 0) begin
      for (int k = 0; k < Q_WIDTH; k++) begin
        scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
        if (scan_sum >= (PTR_W+1)'(Q_WIDTH)) begin
          scan_sum = scan_sum - (PTR_W+1)'(Q_WIDTH);
        end
        scan_idx = scan_sum[PTR_W-1:0];
        if (!found && cand[scan_idx]) begin
          grant_idx = scan_idx;
          found     = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < Q_WIDTH; k++) begin
        if (cand[k]) begin
          grant_idx = PTR_W'(k);
        end
      end
    end
  end

  // Pointer advances to the slot just past the granted queue, with wrap.
  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (PTR_W+1)'(1);
    ptr_d   = ptr_inc[PTR_W-1:0];
    if (ptr_inc == (PTR_W+1)'(Q_WIDTH)) begin
      ptr_d = '0;
    end
  end

  // One-hot pop pulse towards the granted queue.
  for (genvar i = 0; i < Q_WIDTH; i++) begin : g_dealloc
    assign dealloc[i] = load && (grant_idx == PTR_W'(i));
  end

  // Output register: capture on load, drop valid on an idle drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= '0;
      src_q   <= '0;
      dest_q  <= '0;
      flush_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      ptr_q   <= ptr_d;
      addr_q  <= addr_in[grant_idx*ADDR_W +: ADDR_W];
      data_q  <= data_in[grant_idx*CL_SIZE +: CL_SIZE];
      op_q    <= operation_in[grant_idx*OP_W +: OP_W];
      src_q   <= src_in[grant_idx*ID_W +: ID_W];
      dest_q  <= dest_in[grant_idx*ID_W +: ID_W];
      flush_q <= is_flush_in[grant_idx];
    end else if (valid_q && ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_out     = valid_q;
  assign addr_out      = addr_q;
  assign data_out      = data_q;
  // Downstream must never see a stale opcode on an empty slot.
  assign operation_out = valid_q ? op_q : '0;
  assign src_out       = src_q;
  assign dest_out      = dest_q;
  assign is_flush_out  = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_queue_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_arbiter_rr
// Brief    : Self-checking bench for queue_arbiter_rr. A fixed-priority and a
//            round-robin instance share stimulus and are compared every cycle
//            against a queue-level behavioural model, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_arbiter_rr;
  localparam int Q  = 6;
  localparam int CL = 128;
  localparam int AW = 32;
  localparam int OW = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW*Q-1:0] addr_in = '0;
  logic [CL*Q-1:0] data_in = '0;
  logic [OW*Q-1:0] op_in = '0;
  logic [IW*Q-1:0] src_in = '0;
  logic [IW*Q-1:0] dest_in = '0;
  logic [Q-1:0]    flush_in = '0;
  logic [Q-1:0]    valid_in = '0;
  logic            ready_in = 1'b1;

  // index 0 = fixed priority instance, index 1 = round-robin instance
  logic [Q-1:0]  d_dealloc [2];
  logic          d_valid   [2];
  logic [AW-1:0] d_addr    [2];
  logic [CL-1:0] d_data    [2];
  logic [OW-1:0] d_op      [2];
  logic [IW-1:0] d_src     [2];
  logic [IW-1:0] d_dest    [2];
  logic          d_flush   [2];

  always #5 clk = ~clk;

  queue_arbiter_rr #(.CL_SIZE(CL), .Q_WIDTH(Q), .ADDR_W(AW), .OP_W(OW), .ID_W(IW), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .data_in(data_in), .operation_in(op_in),
    .src_in(src_in), .dest_in(dest_in), .is_flush_in(flush_in), .valid_in(valid_in),
    .dealloc(d_dealloc[0]), .valid_out(d_valid[0]), .ready_in(ready_in), .addr_out(d_addr[0]),
    .data_out(d_data[0]), .operation_out(d_op[0]), .src_out(d_src[0]), .dest_out(d_dest[0]),
    .is_flush_out(d_flush[0]));

  queue_arbiter_rr #(.CL_SIZE(CL), .Q_WIDTH(Q), .ADDR_W(AW), .OP_W(OW), .ID_W(IW), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .data_in(data_in), .operation_in(op_in),
    .src_in(src_in), .dest_in(dest_in), .is_flush_in(flush_in), .valid_in(valid_in),
    .dealloc(d_dealloc[1]), .valid_out(d_valid[1]), .ready_in(ready_in), .addr_out(d_addr[1]),
    .data_out(d_data[1]), .operation_out(d_op[1]), .src_out(d_src[1]), .dest_out(d_dest[1]),
    .is_flush_out(d_flush[1]));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // behavioural model state per instance
  bit            m_valid [2];
  int            m_ptr   [2];
  logic [AW-1:0] m_addr  [2];
  logic [CL-1:0] m_data  [2];
  logic [OW-1:0] m_op    [2];
  logic [IW-1:0] m_src   [2];
  logic [IW-1:0] m_dest  [2];
  logic          m_flush [2];

  task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Which queue the rules pick for the current inputs (-1 if none).
  function automatic int model_grant(int mode, int ptr);
    logic [Q-1:0] c;
    c = valid_in;
    if ((valid_in & flush_in) != '0) c = valid_in & flush_in;
    if (c == '0) return -1;
    if (mode == 0) begin
      for (int i = Q - 1; i >= 0; i--) if (c[i]) return i;
    end else begin
      for (int k = 0; k < Q; k++) if (c[(ptr + k) % Q]) return (ptr + k) % Q;
    end
    return -1;
  endfunction

  function automatic logic [Q-1:0] exp_dealloc(int m);
    int g;
    logic [Q-1:0] one;
    one = 1;
    if (!rst_n) return '0;
    g = model_grant(m, m_ptr[m]);
    if (g >= 0 && (!m_valid[m] || ready_in)) return one << g;
    return '0;
  endfunction

  // Model state update on each rising edge using the pre-edge inputs.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int g;
      if (!rst_n) begin
        m_valid[m] = 1'b0; m_ptr[m] = 0; m_addr[m] = '0; m_data[m] = '0;
        m_op[m] = '0; m_src[m] = '0; m_dest[m] = '0; m_flush[m] = 1'b0;
      end else begin
        g = model_grant(m, m_ptr[m]);
        if (g >= 0 && (!m_valid[m] || ready_in)) begin
          m_valid[m] = 1'b1;
          m_ptr[m]   = (g + 1) % Q;
          m_addr[m]  = addr_in[g*AW +: AW];
          m_data[m]  = data_in[g*CL +: CL];
          m_op[m]    = op_in[g*OW +: OW];
          m_src[m]   = src_in[g*IW +: IW];
          m_dest[m]  = dest_in[g*IW +: IW];
          m_flush[m] = flush_in[g];
        end else if (m_valid[m] && ready_in) begin
          m_valid[m] = 1'b0;
        end
      end
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("dealloc[%0d]", m), CL'(d_dealloc[m]), CL'(exp_dealloc(m)));
        check($sformatf("valid_out[%0d]", m), CL'(d_valid[m]), CL'(m_valid[m]));
        check($sformatf("operation_out[%0d]", m), CL'(d_op[m]), m_valid[m] ? CL'(m_op[m]) : '0);
        if (m_valid[m]) begin
          check($sformatf("addr_out[%0d]", m), CL'(d_addr[m]), CL'(m_addr[m]));
          check($sformatf("data_out[%0d]", m), d_data[m], m_data[m]);
          check($sformatf("src_out[%0d]", m), CL'(d_src[m]), CL'(m_src[m]));
          check($sformatf("dest_out[%0d]", m), CL'(d_dest[m]), CL'(m_dest[m]));
          check($sformatf("is_flush_out[%0d]", m), CL'(d_flush[m]), CL'(m_flush[m]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fixed_fields();
    for (int i = 0; i < Q; i++) begin
      addr_in[i*AW +: AW] = 32'hA000_0000 + 32'(i);
      data_in[i*CL +: CL] = {4{32'hD000_0000 + 32'(i)}};
      op_in[i*OW +: OW]   = OW'(i + 1);
      src_in[i*IW +: IW]  = IW'(i);
      dest_in[i*IW +: IW] = IW'(~i);
    end
  endtask

  logic [Q-1:0] rr_seq [7];

  initial begin
    rr_seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    fixed_fields();
    valid_in = 6'h3F;
    ready_in = 1'b1;
    rst_n    = 1'b0;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_dealloc_rr", CL'(d_dealloc[1]), '0);
    check("reset_dealloc_fp", CL'(d_dealloc[0]), '0);
    check("reset_valid_out", CL'(d_valid[1]), '0);
    check("reset_operation_out", CL'(d_op[1]), '0);

    // round-robin rotation with all queues valid
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("rr_dealloc_seq", CL'(d_dealloc[1]), CL'(rr_seq[k]));
      if (k > 0) check("rr_addr_seq", CL'(d_addr[1]), CL'(32'hA000_0000 + 32'((k - 1) % Q)));
      step();
    end

    // fixed priority picks the highest index
    valid_in = 6'b001010;
    @(negedge clk);
    check("fp_dealloc", CL'(d_dealloc[0]), CL'(6'b001000));
    step();
    @(negedge clk);
    check("fp_addr_out", CL'(d_addr[0]), CL'(32'hA000_0003));
    check("fp_data_out", d_data[0], {4{32'hD000_0003}});

    // flush-first from a freshly reset pointer
    step();
    rst_n = 1'b0;
    valid_in = 6'h3F;
    flush_in = 6'b100000;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("flush_dealloc", CL'(d_dealloc[1]), CL'(6'h20));
    step();
    flush_in = '0;
    @(negedge clk);
    check("flush_then_q0", CL'(d_dealloc[1]), CL'(6'h01));

    // backpressure: queue 0 held while ready is low
    step();
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_dealloc", CL'(d_dealloc[1]), '0);
      check("bp_addr_stable", CL'(d_addr[1]), CL'(32'hA000_0000));
      check("bp_valid", CL'(d_valid[1]), CL'(1'b1));
      step();
    end
    ready_in = 1'b1;
    @(negedge clk);
    check("bp_release_dealloc", CL'(d_dealloc[1]), CL'(6'h02));
    step();
    @(negedge clk);
    check("bp_release_addr", CL'(d_addr[1]), CL'(32'hA000_0001));

    // idle drain leaves the pointer where it was (queue 2 was the last grant)
    step();
    valid_in = '0;
    @(negedge clk);
    check("idle_dealloc", CL'(d_dealloc[1]), '0);
    step();
    @(negedge clk);
    check("idle_valid_out", CL'(d_valid[1]), '0);
    check("idle_operation_out", CL'(d_op[1]), '0);
    step();
    valid_in = 6'h3F;
    @(negedge clk);
    check("idle_ptr_kept", CL'(d_dealloc[1]), CL'(6'h08));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < Q; i++) begin
        addr_in[i*AW +: AW] = $urandom;
        for (int j = 0; j < CL / 32; j++) data_in[i*CL + j*32 +: 32] = $urandom;
        op_in[i*OW +: OW]   = OW'($urandom);
        src_in[i*IW +: IW]  = IW'($urandom);
        dest_in[i*IW +: IW] = IW'($urandom);
      end
      valid_in = Q'($urandom);
      flush_in = ($urandom_range(0, 3) == 0) ? Q'($urandom) : '0;
      ready_in = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 199) != 0);
    end
    step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/queue_arbiter_rr.md
# queue_arbiter_rr

Registered, parametrised arbiter that selects one request per cycle from Q_WIDTH cache request queues and presents it on a single valid/ready output channel toward the cache pipeline. It succeeds the combinational fixed-priority queue arbitrator. New behaviour: a selectable round-robin mode, flush-first priority, a backpressure-aware output register, and full-width data on every channel.

## Interface
- CL_SIZE, 128, cache-line data width per channel
- Q_WIDTH, 6, number of request queues (≥2)
- ADDR_W, 32, address width
- OP_W, 3, operation code width
- ID_W, 2, src/dest id width
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (highest index wins)

- clk  in  1  clock. One clock domain; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset
- addr_in  in  ADDR_W*Q_WIDTH  per-queue address; slice i = [i*ADDR_W +: ADDR_W]
- data_in  in  CL_SIZE*Q_WIDTH  per-queue line data
- operation_in  in  OP_W*Q_WIDTH  per-queue opcode
- src_in, dest_in  in  ID_W*Q_WIDTH  per-queue source/destination id
- is_flush_in  in  Q_WIDTH  per-queue flush flag
- valid_in  in  Q_WIDTH  queue i head is valid
- dealloc  out  Q_WIDTH  one-hot pop pulse to the granted queue
- valid_out  out  1  output register holds a request
- ready_in  in  1  downstream accepts the output this cycle
- addr_out, data_out, operation_out, src_out, dest_out, is_flush_out  out  field widths  registered selected request

## Operation
- Load condition: `load = |valid_in && (!valid_out || ready_in)`.
- Candidate set: if any valid queue has is_flush_in=1, only those flush queues are candidates; otherwise all valid queues are candidates.
- RR_MODE=0: grant the highest-index candidate.
- RR_MODE=1: grant the first candidate found scanning upward from pointer `ptr`, wrapping from Q_WIDTH-1 to 0.
  - On load, `ptr` ← (granted index + 1) mod Q_WIDTH.
  - `ptr` is unchanged when there is no load.
- `dealloc` is combinational: one-hot of the grant when load=1, else all zero. Never more than one bit set.
- On load, all output fields capture the granted slice and valid_out ← 1.
- If `valid_out && ready_in && !load`, then valid_out ← 0 and the fields hold their values.
- operation_out is forced to 0 whenever valid_out=0. The other fields are don't-care when invalid.
- Reset (rst_n=0 at a clk edge):
  - valid_out=0, all output fields 0, ptr=0.
  - dealloc=0 while rst_n=0, regardless of valid_in.
- A reset mid-transfer drops the held request. The queue was already popped, so upstream must also be reset.

## Timing
- Latency: a request with valid_in high and the output free at edge N appears on the outputs after edge N, one cycle later; its dealloc pulse is asserted during the cycle before edge N.
- Throughput: one request per cycle while ready_in=1. Simultaneous drain and load in the same cycle is allowed, so there is no bubble.
- Backpressure: while valid_out=1 and ready_in=0:
  - the output fields are stable;
  - dealloc=0;
  - ptr is frozen.
- valid_in may change at any cycle. The grant is evaluated only on the current-cycle inputs; no request is latched before load.
- Every queue with a persistent valid_in is granted within Q_WIDTH loads (RR_MODE=1, no flush traffic).

## Test plan
- Reset: assert rst_n=0 with valid_in=6'h3F → dealloc=0; after release valid_out=0, operation_out=0, ptr=0.
- Round robin, Q_WIDTH=6, valid_in=6'h3F held, ready_in=1:
  - dealloc sequence is 01,02,04,08,10,20,01 on consecutive cycles;
  - addr_out follows one cycle later.
- Fixed priority (RR_MODE=0), valid_in=6'b001010 → dealloc=6'b001000; on the next cycle addr_out = slice 3 and data_out = data_in[3*128 +: 128].
- Flush-first:
  - setup: RR, ptr=0, valid_in=6'h3F, is_flush_in=6'b100000;
  - the grant goes to queue 5 (dealloc=20), then ptr=0;
  - with flush cleared, the next grant goes to queue 0.
- Backpressure:
  - load a request, then hold ready_in=0 for 3 cycles with valid_in=6'h3F;
  - dealloc=0 and the outputs are stable;
  - raise ready_in → the next grant is loaded in the same cycle as the drain.
- Idle drain: valid_in=0, valid_out=1, ready_in=1 → valid_out=0 and operation_out=0 the next cycle; ptr is unchanged.
